// File: rtl/bike_light_pkg.sv
// Shared types and constants for the rear-light mode sequencer.
package bike_light_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RUN       = 2'd1,
    TILT_PEND = 2'd2,
    HAZARD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'd0,
    TURN_LEFT  = 2'd1,
    TURN_RIGHT = 2'd2
  } turn_e;

  localparam logic [1:0] BRK_NONE  = 2'b00;
  localparam logic [1:0] BRK_LIGHT = 2'b01;
  localparam logic [1:0] BRK_HARD  = 2'b11;

  // The unused raw code 10 is treated as a light brake.
  function automatic logic [1:0] brake_map(input logic [1:0] raw);
    case (raw)
      BRK_HARD:         return BRK_HARD;
      2'b10, BRK_LIGHT: return BRK_LIGHT;
      default:          return BRK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: half-period counter with a phase restart and a
// one-cycle pulse marking each high-to-low transition of the blink output.
module blink_gen #(
  parameter int BLINK_HALF = 6_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic blink,
  output logic fall
);

  localparam int CW = $clog2(BLINK_HALF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (rst || !enable) begin
      cnt   <= '0;
      blink <= 1'b0;
      fall  <= 1'b0;
    end else if (restart) begin
      // Restart lands high so the first flash is a full half-period.
      cnt   <= '0;
      blink <= 1'b1;
      fall  <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      blink <= ~blink;
      fall  <= blink;
    end else begin
      cnt   <= cnt + CW'(1);
      fall  <= 1'b0;
    end
  end

endmodule

// File: rtl/light_mode_sequencer.sv
// Rear-light mode sequencer: brake peak-hold, tilt/crash hazard confirmation,
// blink clock and self-cancelling turn signals feeding the light driver.
module light_mode_sequencer
  import bike_light_pkg::*;
#(
  parameter int BLINK_HALF   = 6_000_000,
  parameter int BRAKE_HOLD   = 3_600_000,
  parameter int TILT_CONFIRM = 1_200_000,
  parameter int TURN_BLINKS  = 8
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       PWR,
  input  logic       acc_valid,
  input  logic [1:0] acc_brake,
  input  logic       tilt_raw,
  input  logic       turn_left_req,
  input  logic       turn_right_req,
  output logic [1:0] brake_intensity,
  output logic       tilt_valid,
  output logic       clk_1Hz,
  output logic       turn_left,
  output logic       turn_right,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TILT_CONFIRM + 1);
  localparam int HW = $clog2(BRAKE_HOLD + 1);
  localparam int RW = $clog2(TURN_BLINKS + 1);
  localparam logic [TW-1:0] TC_LAST     = TW'(TILT_CONFIRM - 1);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(BRAKE_HOLD);
  localparam logic [RW-1:0] BLINKS_LOAD = RW'(TURN_BLINKS);

  function automatic logic [HW-1:0] hold_dec(input logic [HW-1:0] v);
    return (v == '0) ? '0 : v - HW'(1);
  endfunction

  mode_e         state;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hold;
  logic [1:0]    last_brk;
  turn_e         turn;
  logic [RW-1:0] turn_rem;
  logic          left_p0, right_p0, left_edge_p1, right_edge_p1;

  logic       flush, active, hazard_entry, turn_ok;
  logic       start_left, start_right, cancel_turn;
  logic       blink_en, blink_restart, blink_fall;
  logic [1:0] sample;

  assign flush    = rst || !PWR;
  assign blink_en = (state != OFF);
  assign mode     = state;
  assign sample   = brake_map(acc_brake);

  always_comb begin
    active       = (state == RUN) || (state == TILT_PEND);
    hazard_entry = 1'b0;
    if (tilt_raw) begin
      if (state == RUN && TILT_CONFIRM == 1) hazard_entry = 1'b1;
      if (state == TILT_PEND && tcnt == TC_LAST) hazard_entry = 1'b1;
    end
    // A hazard entry swallows any turn edge arriving in the same cycle.
    turn_ok       = active && !hazard_entry;
    start_left    = turn_ok && left_edge_p1 && !right_edge_p1 && (turn != TURN_LEFT);
    start_right   = turn_ok && right_edge_p1 && !left_edge_p1 && (turn != TURN_RIGHT);
    cancel_turn   = turn_ok && ((left_edge_p1 && !right_edge_p1 && turn == TURN_LEFT) ||
                                (right_edge_p1 && !left_edge_p1 && turn == TURN_RIGHT));
    blink_restart = hazard_entry || start_left || start_right;
  end

  blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .sys_clk(sys_clk),
    .rst    (flush),
    .enable (blink_en),
    .restart(blink_restart),
    .blink  (clk_1Hz),
    .fall   (blink_fall)
  );

  assign turn_left  = (turn == TURN_LEFT) && clk_1Hz;
  assign turn_right = (turn == TURN_RIGHT) && clk_1Hz;

  always_ff @(posedge sys_clk) begin
    if (flush) begin
      state           <= OFF;
      tilt_valid      <= 1'b0;
      tcnt            <= '0;
      brake_intensity <= BRK_NONE;
      last_brk        <= BRK_NONE;
      hold            <= '0;
      turn            <= TURN_NONE;
      turn_rem        <= '0;
      left_p0         <= 1'b0;
      right_p0        <= 1'b0;
      left_edge_p1    <= 1'b0;
      right_edge_p1   <= 1'b0;
    end else begin
      // p0: request levels; p1: registered rising edges
      left_p0       <= turn_left_req;
      right_p0      <= turn_right_req;
      left_edge_p1  <= turn_left_req && !left_p0;
      right_edge_p1 <= turn_right_req && !right_p0;

      case (state)
        OFF: state <= RUN;
        RUN: begin
          if (tilt_raw) begin
            if (hazard_entry) begin
              state      <= HAZARD;
              tilt_valid <= 1'b1;
              tcnt       <= '0;
            end else begin
              state <= TILT_PEND;
              tcnt  <= TW'(1);
            end
          end
        end
        TILT_PEND: begin
          if (!tilt_raw) begin
            state <= RUN;
            tcnt  <= '0;
          end else if (hazard_entry) begin
            state      <= HAZARD;
            tilt_valid <= 1'b1;
            tcnt       <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        HAZARD: begin
          // tcnt here counts consecutive tilt-free cycles.
          if (tilt_raw) begin
            tcnt <= '0;
          end else if (tcnt == TC_LAST) begin
            state      <= RUN;
            tilt_valid <= 1'b0;
            tcnt       <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= OFF;
      endcase

      if (hazard_entry || state == HAZARD) begin
        brake_intensity <= BRK_NONE;
        last_brk        <= BRK_NONE;
        hold            <= '0;
      end else if (active) begin
        if (acc_valid) begin
          last_brk <= sample;
          hold     <= (sample >= brake_intensity) ? HOLD_LOAD : hold_dec(hold);
          if (sample > brake_intensity || (sample < brake_intensity && hold == '0))
            brake_intensity <= sample;
        end else begin
          // Once the hold expires, drop straight to the most recent sample.
          hold <= hold_dec(hold);
          if (hold == '0) brake_intensity <= last_brk;
        end
      end

      if (hazard_entry || state == HAZARD) begin
        turn     <= TURN_NONE;
        turn_rem <= '0;
      end else if (active) begin
        if (start_left) begin
          turn     <= TURN_LEFT;
          turn_rem <= BLINKS_LOAD;
        end else if (start_right) begin
          turn     <= TURN_RIGHT;
          turn_rem <= BLINKS_LOAD;
        end else if (cancel_turn) begin
          turn     <= TURN_NONE;
          turn_rem <= '0;
        end else if (blink_fall && turn != TURN_NONE) begin
          if (turn_rem == RW'(1)) begin
            turn     <= TURN_NONE;
            turn_rem <= '0;
          end else begin
            turn_rem <= turn_rem - RW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_light_mode_sequencer.sv
// Scoreboard bench for light_mode_sequencer: a time-based reference model
// predicts every cycle's outputs; a monitor compares them as the DUT produces them.
module tb_light_mode_sequencer;

  localparam int HALF = 4;
  localparam int HOLD = 10;
  localparam int TC   = 5;
  localparam int TB   = 2;

  logic       sys_clk = 1'b0;
  logic       rst, pwr, acc_valid, tilt_raw, tl_req, tr_req;
  logic [1:0] acc_brake;
  logic [1:0] brake_intensity, mode;
  logic       tilt_valid, clk_1Hz, turn_left, turn_right;

  light_mode_sequencer #(
    .BLINK_HALF  (HALF),
    .BRAKE_HOLD  (HOLD),
    .TILT_CONFIRM(TC),
    .TURN_BLINKS (TB)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .PWR            (pwr),
    .acc_valid      (acc_valid),
    .acc_brake      (acc_brake),
    .tilt_raw       (tilt_raw),
    .turn_left_req  (tl_req),
    .turn_right_req (tr_req),
    .brake_intensity(brake_intensity),
    .tilt_valid     (tilt_valid),
    .clk_1Hz        (clk_1Hz),
    .turn_left      (turn_left),
    .turn_right     (turn_right),
    .mode           (mode)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0] md;
    logic [1:0] brk;
    logic       tv;
    logic       blink;
    logic       tl;
    logic       tr;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   mon_idx = 0;

  // Reference model state: time is the index of the clock edge being predicted.
  int t = 0;
  int m_mode = 0, m_hi = 0, m_lo = 0;
  int m_lvl = 0, m_last = 0, m_hold_end = -100;
  int m_dir = 0, m_rem = 0;
  int m_o = 0, m_ph = 0;
  bit m_en = 0, m_lprev = 0, m_rprev = 0, m_le = 0, m_re = 0, m_fall = 0, m_blink_prev = 0;

  function automatic bit blink_at(input int tt);
    if (!m_en) return 1'b0;
    return bit'((m_ph + (tt - m_o) / HALF) % 2);
  endfunction

  function automatic void model_step();
    int   pm, s;
    bit   act, hz_in, restart, nb;
    obs_t e;
    hz_in   = 0;
    restart = 0;
    if (rst || !pwr) begin
      m_mode = 0; m_hi = 0; m_lo = 0;
      m_lvl = 0; m_last = 0; m_hold_end = -100;
      m_dir = 0; m_rem = 0;
      m_lprev = 0; m_rprev = 0; m_le = 0; m_re = 0; m_fall = 0;
      m_en = 0; m_o = t; m_ph = 0;
    end else begin
      pm  = m_mode;
      act = (pm == 1 || pm == 2);
      if (pm == 0) m_mode = 1;
      else if (act) begin
        if (tilt_raw) begin
          m_hi++;
          if (m_hi >= TC) begin m_mode = 3; hz_in = 1; m_hi = 0; m_lo = 0; end
          else m_mode = 2;
        end else begin
          m_hi = 0; m_mode = 1;
        end
      end else begin
        if (tilt_raw) m_lo = 0; else m_lo++;
        if (m_lo >= TC) begin m_mode = 1; m_lo = 0; m_hi = 0; end
      end

      if (hz_in || pm == 3) begin
        m_lvl = 0; m_last = 0; m_hold_end = -100;
      end else if (act) begin
        if (acc_valid) begin
          s = (acc_brake == 2'b10) ? 1 : int'(acc_brake);
          m_last = s;
          if (s > m_lvl) begin m_lvl = s; m_hold_end = t + HOLD; end
          else if (s == m_lvl) m_hold_end = t + HOLD;
          else if (t > m_hold_end) m_lvl = s;
        end else if (t > m_hold_end) begin
          m_lvl = m_last;
        end
      end

      if (hz_in || pm == 3) begin
        m_dir = 0; m_rem = 0;
      end else if (act) begin
        if (m_le && !m_re) begin
          if (m_dir == 1) begin m_dir = 0; m_rem = 0; end
          else begin m_dir = 1; m_rem = TB; restart = 1; end
        end else if (m_re && !m_le) begin
          if (m_dir == 2) begin m_dir = 0; m_rem = 0; end
          else begin m_dir = 2; m_rem = TB; restart = 1; end
        end else if (m_fall && m_dir != 0) begin
          m_rem--;
          if (m_rem == 0) m_dir = 0;
        end
      end
      restart = restart || hz_in;

      if (pm == 0) begin m_en = 1; m_o = t; m_ph = 0; end
      else if (restart) begin m_o = t; m_ph = 1; end
      nb     = blink_at(t);
      m_fall = !restart && m_blink_prev && !nb;

      m_le = tl_req && !m_lprev; m_lprev = tl_req;
      m_re = tr_req && !m_rprev; m_rprev = tr_req;
    end
    m_blink_prev = blink_at(t);
    e.md    = 2'(m_mode);
    e.brk   = 2'(m_lvl);
    e.tv    = (m_mode == 3);
    e.blink = m_blink_prev;
    e.tl    = (m_dir == 1) && m_blink_prev;
    e.tr    = (m_dir == 2) && m_blink_prev;
    exp_q.push_back(e);
    t++;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge sys_clk);
    end
  endtask

  task automatic strobe(input logic [1:0] v);
    acc_valid = 1'b1;
    acc_brake = v;
    step(1);
    acc_valid = 1'b0;
  endtask

  always @(posedge sys_clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {mode, brake_intensity, tilt_valid, clk_1Hz, turn_left, turn_right};
      checks++;
      if (a === e) passes++;
      else $display("FAIL outputs_cycle%0d: got mode=%0d brk=%0d tv=%0b blink=%0b tl=%0b tr=%0b, expected mode=%0d brk=%0d tv=%0b blink=%0b tl=%0b tr=%0b",
                    mon_idx, a.md, a.brk, a.tv, a.blink, a.tl, a.tr,
                    e.md, e.brk, e.tv, e.blink, e.tl, e.tr);
      mon_idx++;
    end
  end

  initial begin
    int tilt_hold;
    rst = 1'b1; pwr = 1'b1; acc_valid = 1'b0; acc_brake = 2'b00;
    tilt_raw = 1'b0; tl_req = 1'b0; tr_req = 1'b0;

    // Reset, then power-up into RUN
    step(3);
    rst = 1'b0;
    step(3);

    // Brake peak-hold: hard, then light three cycles later, then a 10 code
    strobe(2'b11);
    step(2);
    strobe(2'b01);
    step(14);
    strobe(2'b10);
    step(3);
    strobe(2'b00);
    step(13);

    // Tilt: 4 highs abort, 5 highs enter HAZARD, 5 lows leave
    strobe(2'b11);
    tilt_raw = 1'b1; step(4);
    tilt_raw = 1'b0; step(3);
    tilt_raw = 1'b1; step(5);
    step(2);
    tilt_raw = 1'b0; step(3);
    tilt_raw = 1'b1; step(1);
    tilt_raw = 1'b0; step(7);

    // Left turn with auto-cancel
    tl_req = 1'b1; step(1);
    tl_req = 1'b0; step(22);

    // Left, switch to right, simultaneous edges, then cancel right
    tl_req = 1'b1; step(1);
    tl_req = 1'b0; step(5);
    tr_req = 1'b1; step(1);
    tr_req = 1'b0; step(5);
    tl_req = 1'b1; tr_req = 1'b1; step(1);
    tl_req = 1'b0; tr_req = 1'b0; step(4);
    tr_req = 1'b1; step(1);
    tr_req = 1'b0; step(4);

    // Turn edge landing on the HAZARD entry cycle
    tilt_raw = 1'b1; step(3);
    tl_req = 1'b1; step(1);
    step(1);
    tl_req = 1'b0; tilt_raw = 1'b0; step(8);

    // PWR drop mid-turn with hard brake held
    strobe(2'b11);
    tl_req = 1'b1; step(1);
    tl_req = 1'b0; step(4);
    pwr = 1'b0; step(1);
    pwr = 1'b1; step(20);

    // Randomized traffic
    tilt_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      acc_valid = ($urandom_range(0, 5) == 0);
      acc_brake = 2'($urandom_range(0, 3));
      if (tilt_hold == 0) begin
        tilt_raw  = ($urandom_range(0, 2) == 0);
        tilt_hold = $urandom_range(1, 9);
      end else begin
        tilt_hold--;
      end
      if ($urandom_range(0, 15) == 0) tl_req = ~tl_req;
      if ($urandom_range(0, 15) == 0) tr_req = ~tr_req;
      pwr = ($urandom_range(0, 299) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge sys_clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
